// File: rtl/rename_alloc_ctrl_if.sv
// Rename allocation / commit-free handshake bundle between the rename stage and rename_alloc_ctrl.
// The rename/commit side drives through master; the allocator sits on slave.
interface rename_alloc_ctrl_if;
  logic            alloc_valid;
  logic [3:0]      alloc_rd_vec;
  logic            alloc_ready;
  logic [3:0][6:0] alloc_preg_vec;
  logic [3:0]      rat_update_vec;
  logic [3:0]      commit_free_vec;
  logic [3:0][6:0] commit_free_preg;
  logic [2:0]      commit_alloc_num;
  logic            flush_valid;
  logic            rat_recover_valid;
  logic [7:0]      free_count;
  logic            alloc_err;

  modport master (
    output alloc_valid, alloc_rd_vec, commit_free_vec, commit_free_preg,
           commit_alloc_num, flush_valid,
    input  alloc_ready, alloc_preg_vec, rat_update_vec, rat_recover_valid,
           free_count, alloc_err
  );

  modport slave (
    input  alloc_valid, alloc_rd_vec, commit_free_vec, commit_free_preg,
           commit_alloc_num, flush_valid,
    output alloc_ready, alloc_preg_vec, rat_update_vec, rat_recover_valid,
           free_count, alloc_err
  );
endinterface

// File: rtl/rename_alloc_ctrl.sv
// Physical-register free list (128-entry circular FIFO) with speculative/committed heads and flush recovery.
// Optional sanity checker on alloc_err is built only when RENAME_ALLOC_CHECK_EN is defined.
//
// state    | meaning
// RUN      | normal allocation
// RECOVER  | one cycle after a flush; RAT is being restored, no allocation
module rename_alloc_ctrl (
  input logic              clk,
  input logic              rst_n,
  rename_alloc_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [7:0]      spec_head, commit_head, tail;
  logic [7:0]      spec_head_nxt, commit_head_nxt, tail_nxt;
  logic [7:0]      free_cnt_q, free_cnt_nxt;
  logic            recover_q;
  logic [6:0]      fifo [128];

  logic [2:0]      alloc_num, free_num;
  logic [2:0]      alloc_pre, free_pre;
  logic [6:0]      rd_idx [4];
  logic [6:0]      wr_idx [4];
  logic [3:0]      keep;
  logic [3:0][6:0] preg_vec;
  logic            ready, alloc_fire;

  // Slot i reads the entry after the pregs claimed by older slots; frees are packed the same way.
  always_comb begin
    alloc_pre = 3'd0;
    free_pre  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      rd_idx[i]   = spec_head[6:0] + {4'd0, alloc_pre};
      preg_vec[i] = bus.alloc_rd_vec[i] ? fifo[rd_idx[i]] : 7'd0;
      alloc_pre   = alloc_pre + {2'd0, bus.alloc_rd_vec[i]};
      keep[i]     = bus.commit_free_vec[i] && (bus.commit_free_preg[i] != 7'd0);
      wr_idx[i]   = tail[6:0] + {4'd0, free_pre};
      free_pre    = free_pre + {2'd0, keep[i]};
    end
    alloc_num = alloc_pre;
    free_num  = free_pre;
  end

  assign ready      = (state == ST_RUN) && !bus.flush_valid &&
                      ({5'd0, alloc_num} <= free_cnt_q);
  assign alloc_fire = bus.alloc_valid && ready;

  assign bus.alloc_ready       = ready;
  assign bus.alloc_preg_vec    = preg_vec;
  assign bus.rat_update_vec    = alloc_fire ? bus.alloc_rd_vec : 4'd0;
  assign bus.rat_recover_valid = recover_q;
  assign bus.free_count        = free_cnt_q;

  always_comb begin
    commit_head_nxt = commit_head + {5'd0, bus.commit_alloc_num};
    tail_nxt        = tail + {5'd0, free_num};
    if (bus.flush_valid)
      spec_head_nxt = commit_head_nxt;
    else if (alloc_fire)
      spec_head_nxt = spec_head + {5'd0, alloc_num};
    else
      spec_head_nxt = spec_head;
    free_cnt_nxt = tail_nxt - spec_head_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     state_nxt = bus.flush_valid ? ST_RECOVER : ST_RUN;
      ST_RECOVER: state_nxt = bus.flush_valid ? ST_RECOVER : ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      spec_head   <= 8'd0;
      commit_head <= 8'd0;
      tail        <= 8'd96;
      free_cnt_q  <= 8'd96;
      recover_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      spec_head   <= spec_head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
      free_cnt_q  <= free_cnt_nxt;
      recover_q   <= bus.flush_valid;
    end
  end

  // Pregs 32..127 start free; 0..31 hold the initial architectural mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 128; k++)
        fifo[k] <= (k < 96) ? 7'(k + 32) : 7'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (keep[i])
          fifo[wr_idx[i]] <= bus.commit_free_preg[i];
    end
  end

`ifdef RENAME_ALLOC_CHECK_EN
  logic       err_q;
  logic [7:0] spec_lead;

  assign spec_lead = spec_head_nxt - commit_head_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (free_cnt_nxt[7] || spec_lead[7])
      err_q <= 1'b1;
  end

  assign bus.alloc_err = err_q;
`else
  assign bus.alloc_err = 1'b0;
`endif

endmodule
